// File: rtl/ifetch_queue.sv
// Instruction prefetch stage: single-outstanding imem fetch feeding a
// small PC-tagged instruction FIFO, with branch redirect and flush.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          CNTW     = 3,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [7:0]      redirect_pc,
    output logic            imem_req,
    output logic [7:0]      imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst_data,
    output logic [7:0]      inst_pc,
    input  logic            inst_ready,
    output logic [CNTW-1:0] fill_level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW:0] DEPTH_C = (CNTW+1)'(DEPTH);

    typedef enum logic {RUN, DISCARD} state_e;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      pc_q, pc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;

    logic [31:0]     data_mem [DEPTH];
    logic [7:0]      pc_mem   [DEPTH];

    logic            ack;
    logic            pop;
    logic            push;
    logic [CNTW:0]   cnt_n;
    logic [7:0]      tgt;
    logic [7:0]      nxt;

    assign ack = req_q & imem_ack;
    assign pop = (cnt_q != '0) & inst_ready;
    assign tgt = redirect_pc & 8'hFC;
    assign nxt = addr_q + 8'd4;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        push    = 1'b0;
        cnt_n   = {1'b0, cnt_q};
        if (redirect_valid) begin
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
            pc_d  = tgt;
            if (!req_q || imem_ack) begin
                state_d = RUN;
                req_d   = 1'b1;
                addr_d  = tgt;
            end else begin
                state_d = DISCARD;
            end
        end else if (state_q == DISCARD) begin
            // FIFO is empty here; the stale ack is dropped
            if (ack) begin
                state_d = RUN;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end
        end else begin
            push  = ack;
            cnt_n = {1'b0, cnt_q} + {{CNTW{1'b0}}, push}
                    - {{CNTW{1'b0}}, pop};
            cnt_d = cnt_n[CNTW-1:0];
            if (pop)  rd_d = rd_q + PW'(1);
            if (push) wr_d = wr_q + PW'(1);
            if (ack) begin
                pc_d   = nxt;
                addr_d = nxt;
                req_d  = (cnt_n < DEPTH_C);
            end else if (!req_q && (cnt_n < DEPTH_C)) begin
                req_d  = 1'b1;
                addr_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_q] <= imem_rdata;
            pc_mem[wr_q]   <= addr_q;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = (cnt_q != '0);
    assign inst_data  = data_mem[rd_q];
    assign inst_pc    = pc_mem[rd_q];
    assign fill_level = cnt_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus random traffic,
// all checked against a queue-based behavioural model.
module tb_ifetch_queue;

    localparam int         DEPTH    = 4;
    localparam int         CNTW     = 3;
    localparam logic [7:0] RESET_PC = 8'h00;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  pc;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            redirect_valid;
    logic [7:0]      redirect_pc;
    logic            imem_req;
    logic [7:0]      imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic [31:0]     inst_data;
    logic [7:0]      inst_pc;
    logic            inst_ready;
    logic [CNTW-1:0] fill_level;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    ent_t       mq[$];
    logic       m_req;
    logic [7:0] m_addr;
    logic [7:0] m_pc;
    logic       m_disc;

    ifetch_queue #(
        .DEPTH(DEPTH), .CNTW(CNTW), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_ready(inst_ready),
        .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_req  = 1'b0;
        m_addr = RESET_PC;
        m_pc   = RESET_PC;
        m_disc = 1'b0;
    endtask

    // One cycle: compare DUT to model, drive inputs, advance model.
    task automatic cyc(input logic ack, input logic rdy,
                       input logic rv = 1'b0,
                       input logic [7:0] rpc = 8'h00);
        logic [31:0] rd;
        logic        ackd;
        logic [7:0]  tgt;
        n_chk++;
        if (imem_req !== m_req) begin
            n_fail++;
            $display("FAIL model imem_req: got %b want %b", imem_req, m_req);
        end
        if (m_req) begin
            n_chk++;
            if (imem_addr !== m_addr) begin
                n_fail++;
                $display("FAIL model imem_addr: got %h want %h",
                         imem_addr, m_addr);
            end
        end
        n_chk++;
        if (inst_valid !== (mq.size() != 0)) begin
            n_fail++;
            $display("FAIL model inst_valid: got %b want %b",
                     inst_valid, mq.size() != 0);
        end
        if (mq.size() != 0) begin
            n_chk++;
            if ({inst_data, inst_pc} !== {mq[0].data, mq[0].pc}) begin
                n_fail++;
                $display("FAIL model head: got %h/%h want %h/%h",
                         inst_data, inst_pc, mq[0].data, mq[0].pc);
            end
        end
        n_chk++;
        if (fill_level !== CNTW'(mq.size())) begin
            n_fail++;
            $display("FAIL model fill_level: got %0d want %0d",
                     fill_level, mq.size());
        end
        rd             = $urandom;
        imem_ack       = ack;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rdata     = rd;
        ackd = m_req && ack;
        if (rv) begin
            tgt = {rpc[7:2], 2'b00};
            mq.delete();
            m_pc = tgt;
            if (!m_req || ack) begin
                m_req  = 1'b1;
                m_addr = tgt;
                m_disc = 1'b0;
            end else begin
                m_disc = 1'b1;
            end
        end else if (m_disc) begin
            if (ackd) begin
                m_disc = 1'b0;
                m_req  = 1'b1;
                m_addr = m_pc;
            end
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (ackd) begin
                mq.push_back('{data: rd, pc: m_addr});
                m_pc   = m_addr + 8'd4;
                m_addr = m_pc;
                m_req  = (mq.size() < DEPTH);
            end else if (!m_req && mq.size() < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_pc;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        imem_ack       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        imem_rdata     = 32'h0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({imem_req, inst_valid, fill_level} !== {2'b00, 3'd0}) begin
            n_fail++;
            $display("FAIL reset flags: got %b%b%0d want 000",
                     imem_req, inst_valid, fill_level);
        end
        n_chk++;
        if (imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset addr: got %h want %h", imem_addr, RESET_PC);
        end
        cyc(1'b0, 1'b1);
    endtask

    task automatic test_zero_wait();
        do_reset();
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (imem_addr !== 8'(4 * i) || !imem_req) begin
                n_fail++;
                $display("FAIL zw addr: got %h req %b want %h",
                         imem_addr, imem_req, 8'(4 * i));
            end
            if (i > 0) begin
                n_chk++;
                if (!inst_valid || inst_pc !== 8'(4 * (i - 1))) begin
                    n_fail++;
                    $display("FAIL zw inst_pc: got %h want %h",
                             inst_pc, 8'(4 * (i - 1)));
                end
            end
            cyc(1'b1, 1'b1);
        end
    endtask

    task automatic test_full();
        do_reset();
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
        n_chk++;
        if (imem_req !== 1'b0 || fill_level !== 3'd4) begin
            n_fail++;
            $display("FAIL full: got req %b fill %0d want 0/4",
                     imem_req, fill_level);
        end
        cyc(1'b0, 1'b1);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin
            n_fail++;
            $display("FAIL full refill: got req %b addr %h want 1/10",
                     imem_req, imem_addr);
        end
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_latency();
        do_reset();
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h08) begin
                n_fail++;
                $display("FAIL lat hold: got req %b addr %h want 1/08",
                         imem_req, imem_addr);
            end
            cyc(k == 2, 1'b1);
        end
        n_chk++;
        if (fill_level !== 3'd1 || inst_pc !== 8'h08) begin
            n_fail++;
            $display("FAIL lat push: got fill %0d pc %h want 1/08",
                     fill_level, inst_pc);
        end
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
    endtask

    task automatic test_redirect();
        do_reset();
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 8'h1B);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h0C || inst_valid) begin
            n_fail++;
            $display("FAIL redir hold: got req %b addr %h v %b want 1/0C/0",
                     imem_req, imem_addr, inst_valid);
        end
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        n_chk++;
        if (inst_valid !== 1'b0 || imem_addr !== 8'h18) begin
            n_fail++;
            $display("FAIL redir drop: got v %b addr %h want 0/18",
                     inst_valid, imem_addr);
        end
        cyc(1'b1, 1'b0);
        n_chk++;
        if (inst_valid !== 1'b1 || inst_pc !== 8'h18) begin
            n_fail++;
            $display("FAIL redir data: got v %b pc %h want 1/18",
                     inst_valid, inst_pc);
        end
        cyc(1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        logic [7:0] seq [4];
        seq = '{8'hF8, 8'hFC, 8'h00, 8'h04};
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 8'hF8);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (imem_addr !== seq[i]) begin
                n_fail++;
                $display("FAIL wrap addr: got %h want %h", imem_addr, seq[i]);
            end
            if (i > 0) begin
                n_chk++;
                if (inst_pc !== seq[i - 1]) begin
                    n_fail++;
                    $display("FAIL wrap pc: got %h want %h",
                             inst_pc, seq[i - 1]);
                end
            end
            cyc(1'b1, 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        #1;
        n_chk++;
        if ({imem_req, inst_valid, fill_level} !== {2'b00, 3'd0}) begin
            n_fail++;
            $display("FAIL midrst: got %b%b%0d want 000",
                     imem_req, inst_valid, fill_level);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL midrst restart: got req %b addr %h want 1/%h",
                     imem_req, imem_addr, RESET_PC);
        end
        cyc(1'b1, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic       ack;
            logic       rdy;
            logic       rv;
            ack = ($urandom_range(0, 2) == 0) || (i % 512 < 100);
            rdy = ($urandom_range(0, 3) != 0) || (i % 400 < 60);
            rdy = rdy && !(i % 300 > 250);
            rv  = ($urandom_range(0, 29) == 0);
            cyc(ack, rdy, rv, 8'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_full();
        test_latency();
        test_redirect();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch prefetch stage that sits directly upstream of the decode/control/register-file stage.
- Generates word-aligned 8-bit byte addresses toward instruction memory using a req/ack handshake that tolerates variable latency.
- Buffers returned 32-bit instructions, each tagged with its PC, in a small FIFO.
- Presents instructions downstream with valid/ready; a branch redirect flushes the FIFO and restarts fetch.

Parameters:
- DEPTH, 4: FIFO entries (instruction + PC); power of two, 2..16.
- CNTW, 3: occupancy counter width; must hold the value DEPTH.
- RESET_PC, 8'h00: first fetch address after reset; low 2 bits must be 00.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- redirect_valid  in  1  branch taken this cycle; flush and refetch.
- redirect_pc  in  8  redirect target byte address; bits [1:0] ignored and treated as 00.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  8  fetch byte address; held stable while imem_req=1 and no ack.
- imem_ack  in  1  memory returns imem_rdata this cycle; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  FIFO head valid.
- inst_data  out  32  head instruction.
- inst_pc  out  8  head instruction byte address.
- inst_ready  in  1  downstream consumes head when inst_valid=1.
- fill_level  out  CNTW  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC.
  - FIFO empty: count=0, inst_valid=0, fill_level=0.
  - State=RUN.
  - FIFO storage is not cleared; inst_data/inst_pc are don't-care while inst_valid=0.
- First rising edge with rst=1: imem_req becomes 1, imem_addr=RESET_PC.
- Memory handshake:
  - At most one request is outstanding.
  - Once imem_req=1, imem_req and imem_addr stay constant until an edge where imem_ack=1.
  - An ack may arrive in the same cycle as the request (zero-wait memory).
  - imem_ack while imem_req=0 is ignored.
- Issue rule (RUN):
  - A new request is raised only when the FIFO will have a free slot for its data, so an accepted ack never overflows.
  - At an ack edge, imem_req stays 1 with imem_addr+4 when (count after this edge's push/pop) < DEPTH; otherwise imem_req goes to 0.
  - While imem_req=0, it is raised with the current fetch_pc once count < DEPTH.
  - Zero-wait memory with a consumer that is always ready sustains 1 instruction per cycle.
- Address arithmetic: 8-bit modulo; 8'hFC+4 wraps to 8'h00. No error flag.
- FIFO:
  - Push on an accepted ack in RUN: entry = {imem_rdata, imem_addr}.
  - Pop when inst_valid & inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - inst_valid = (count != 0); inst_data/inst_pc are driven combinationally from the head entry.
  - Data appears at the output one cycle after the ack edge.
  - Read/write pointers wrap modulo DEPTH.
- Redirect (highest priority, sampled at the edge):
  - FIFO flushed: count=0, inst_valid=0 next cycle.
  - Any pop in the same cycle is void, and no push occurs.
  - fetch_pc = {redirect_pc[7:2], 2'b00}.
  - Case A, imem_req=0 or imem_ack=1 this cycle: next cycle imem_req=1, imem_addr=redirect target. Any ack data this cycle is dropped.
  - Case B, imem_req=1 with no ack: state goes to DISCARD. imem_req/imem_addr stay unchanged until ack; that ack's data is dropped. At the ack edge, state returns to RUN and the next cycle issues the redirect target.
- Redirect while already in DISCARD: the newest target overwrites fetch_pc; the state stays DISCARD.
- FSM states and transitions:
  - RUN -> DISCARD on Case B.
  - DISCARD -> RUN on imem_ack.
  - No other states.
- Full FIFO (count=DEPTH): no request is outstanding. inst_valid=1 holds the head until popped.
- Asserting reset mid-request immediately drops imem_req; the memory must tolerate an abandoned request.

Test Plan:
- Reset release, zero-wait memory (ack=req every cycle), inst_ready=1 -> addresses 00,04,08,0C on consecutive cycles; inst_pc follows one cycle later with matching words; fill_level stays ≤1.
- inst_ready=0, DEPTH=4, zero-wait -> exactly 4 acks accepted; imem_req=0 afterwards; fill_level=4; one pop -> one new request at address 10.
- Memory latency 3 cycles -> imem_addr stays 08 for 3 cycles with imem_req=1; exactly one push per ack; no duplicate entries.
- Redirect to 8'h1B while a request to 0C is waiting -> state DISCARD; 0C data dropped; next request addr=18; inst_valid=0 until 18 data arrives; inst_pc=18.
- Start fetch at RESET_PC=8'hF8 -> addresses F8, FC, 00, 04; inst_pc sequence identical.
- Assert rst low mid-request with 2 entries queued -> imem_req=0, inst_valid=0, fill_level=0 immediately; after release, fetch restarts at RESET_PC.
